// File: rtl/test_pkg.sv
// Shared constants, kernel coefficients and ROM contents for the 3-tap convolver.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package test_pkg;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = $clog2(DEPTH);

    // Smoothing kernel {1,2,1} normalised by a right shift of 2 (divide by 4).
    localparam int K0    = 1;
    localparam int K1    = 2;
    localparam int K2    = 1;
    localparam int SHIFT = 2;

    // Width of the multiply-accumulate; 4*255 = 1020 fits in 10 bits.
    localparam int MAC_W = DATA_W + 2;

    // ROM entry k holds a linear ramp 4, 8, ..., 64.
    function automatic logic [DATA_W-1:0] rom_init(input int idx);
        return DATA_W'(4 * (idx + 1));
    endfunction

endpackage

// File: rtl/test_sample_rom.sv
// Fixed sample ROM, contents taken from the package init function.
// Latency: combinational read, data valid in the same cycle as the address.
// Backpressure: none; the ROM is always readable.
module test_sample_rom
    import test_pkg::*;
#(
    parameter int RDEPTH = DEPTH,
    parameter int RWIDTH = DATA_W,
    parameter int RADDR  = $clog2(RDEPTH)
) (
    input  logic [RADDR-1:0]  addr_i,
    output logic [RWIDTH-1:0] data_o
);

    logic [RWIDTH-1:0] mem [RDEPTH];

    // Constant contents, one tie-off per entry.
    for (genvar k = 0; k < RDEPTH; k++) begin : g_rom
        assign mem[k] = RWIDTH'(rom_init(k));
    end

    assign data_o = mem[addr_i];

endmodule

// File: rtl/test.sv
// Streaming {1,2,1}/4 convolution over the sample ROM plus a mod-256 running sum.
// Latency: outputs reflect a sample right after the edge that consumes it; 1 sample/clock.
// Backpressure: read=0 freezes every register; there is no output handshake.
module test
    import test_pkg::*;
(
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              read,
    output logic [DATA_W-1:0] CONV_OUT,
    output logic [DATA_W-1:0] sumout
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] t0_q, t0_d;
    logic [DATA_W-1:0] t1_q, t1_d;
    logic [DATA_W-1:0] conv_q, conv_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [DATA_W-1:0] sample;
    logic [MAC_W-1:0]  mac;

    test_sample_rom #(
        .RDEPTH (DEPTH),
        .RWIDTH (DATA_W),
        .RADDR  (ADDR_W)
    ) u_rom (
        .addr_i (addr_q),
        .data_o (sample)
    );

    // Kernel MAC at full width so the sum never overflows before the shift.
    assign mac = MAC_W'(sample) * MAC_W'(K0)
               + MAC_W'(t0_q)   * MAC_W'(K1)
               + MAC_W'(t1_q)   * MAC_W'(K2);

    // Next state: advance taps, result, sum and address only when read is high.
    always_comb begin
        addr_d = addr_q;
        t0_d   = t0_q;
        t1_d   = t1_q;
        conv_d = conv_q;
        sum_d  = sum_q;
        if (read) begin
            conv_d = DATA_W'(mac >> SHIFT);
            t1_d   = t0_q;
            t0_d   = sample;
            sum_d  = sum_q + sample;      // natural 8-bit wrap
            addr_d = addr_q + 1'b1;       // wraps 15 -> 0, taps kept across the wrap
        end
    end

    // State registers with synchronous reset taking priority over read.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            addr_q <= '0;
            t0_q   <= '0;
            t1_q   <= '0;
            conv_q <= '0;
            sum_q  <= '0;
        end else begin
            addr_q <= addr_d;
            t0_q   <= t0_d;
            t1_q   <= t1_d;
            conv_q <= conv_d;
            sum_q  <= sum_d;
        end
    end

    assign CONV_OUT = conv_q;
    assign sumout   = sum_q;

endmodule

// File: tb/tb_test.sv
// Directed bench for the convolver: reset, start-up, stall, full pass, wrap, mid-stream reset.
// Latency: checks sample outputs on the falling edge after each rising edge.
// Backpressure: exercised through read=0 stall cycles.
module tb_test;

    logic       CLK;
    logic       RSTn;
    logic       read;
    logic [7:0] CONV_OUT;
    logic [7:0] sumout;

    int n_checks = 0;
    int n_errors = 0;

    test dut (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .read     (read),
        .CONV_OUT (CONV_OUT),
        .sumout   (sumout)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] exp_conv, input logic [7:0] exp_sum);
        check({tag, ".conv"}, CONV_OUT, exp_conv);
        check({tag, ".sum"},  sumout,   exp_sum);
    endtask

    // Apply inputs at the falling edge, clock once, return at the next falling edge.
    task automatic tick(input logic rst_n, input logic rd);
        RSTn = rst_n;
        read = rd;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Expected outputs after the k-th read from reset on the ramp 4,8,...,64 (k <= 16).
    function automatic logic [7:0] exp_conv_k(input int k);
        if (k == 1) return 8'd1;
        if (k == 2) return 8'd4;
        return 8'(4 * (k - 1));
    endfunction

    function automatic logic [7:0] exp_sum_k(input int k);
        return 8'((2 * k * (k + 1)) % 256);
    endfunction

    initial begin
        RSTn = 1'b0;
        read = 1'b1;
        @(negedge CLK);

        // Reset with read high: reset wins, then hold reset for 3 more edges.
        tick(1'b0, 1'b1);
        check_out("reset0", 8'd0, 8'd0);
        for (int i = 1; i <= 3; i++) begin
            tick(1'b0, 1'b1);
            check_out($sformatf("reset%0d", i), 8'd0, 8'd0);
        end

        // Start-up: partial outputs while the taps fill.
        tick(1'b1, 1'b1); check_out("start1", 8'd1,  8'd4);
        tick(1'b1, 1'b1); check_out("start2", 8'd4,  8'd12);
        tick(1'b1, 1'b1); check_out("start3", 8'd8,  8'd24);
        tick(1'b1, 1'b1); check_out("start4", 8'd12, 8'd40);

        // Stall: everything holds.
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b0);
            check_out($sformatf("stall%0d", i), 8'd12, 8'd40);
        end

        // Resume: read 5 consumes s=20 -> (20+32+12)>>2 = 16.
        tick(1'b1, 1'b1); check_out("resume5", 8'd16, 8'd60);

        // Remainder of the first pass, reads 6..16.
        for (int k = 6; k <= 16; k++) begin
            tick(1'b1, 1'b1);
            check_out($sformatf("pass%0d", k), exp_conv_k(k), exp_sum_k(k));
        end
        check_out("pass_end", 8'd60, 8'd32);

        // Wrap across the ROM boundary with history retained.
        tick(1'b1, 1'b1); check_out("wrap17", 8'd48, 8'd36);
        tick(1'b1, 1'b1); check_out("wrap18", 8'd20, 8'd44);

        // Fresh reset, then 7 reads, then a one-edge reset mid-stream.
        tick(1'b0, 1'b0); check_out("rst_b", 8'd0, 8'd0);
        for (int k = 1; k <= 7; k++) begin
            tick(1'b1, 1'b1);
            check_out($sformatf("pre%0d", k), exp_conv_k(k), exp_sum_k(k));
        end
        tick(1'b0, 1'b1); check_out("midrst", 8'd0, 8'd0);

        // Restart must match the start-up sequence exactly.
        tick(1'b1, 1'b1); check_out("restart1", 8'd1,  8'd4);
        tick(1'b1, 1'b1); check_out("restart2", 8'd4,  8'd12);
        tick(1'b1, 1'b1); check_out("restart3", 8'd8,  8'd24);
        tick(1'b1, 1'b1); check_out("restart4", 8'd12, 8'd40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
